// File: rtl/esas_sqrt_pipe.sv
// Three-stage pipelined ESAS square-root approximator: normalise, linear mantissa root
// with sqrt(2) compensation for odd exponents, then exponent shift with saturation.
module esas_sqrt_pipe #(
    parameter int W    = 32,
    parameter int M    = 16,
    parameter int FRAC = 8,
    parameter int ID_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [ID_W-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W/2+FRAC-1:0]   out_data,
    output logic [ID_W-1:0]       out_tag,
    output logic                  out_zero,
    output logic                  out_sat
);
    localparam int OUT_W = W/2 + FRAC;
    localparam int PW    = $clog2(W);
    localparam int RW    = M + 1 + W/2;

    // Handshake: a transfer happens on any edge where valid && ready. All three
    // stages share one advance enable, so a stalled output freezes the whole
    // pipe and the input is refused in exactly the same cycles.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: leading-one detect and normalise ----------------
    logic [PW-1:0] lead_idx;
    logic [PW-1:0] norm_sh;
    logic [W-1:0]  norm_a;
    logic [M-1:0]  norm_m;

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (in_data[i]) lead_idx = PW'(i);
        end
    end

    assign norm_sh = PW'(W-1) - lead_idx;
    assign norm_a  = in_data << norm_sh;
    assign norm_m  = M'(norm_a >> (W-M));

    logic            s1_valid;
    logic            s1_zero;
    logic [M-1:0]    s1_m;
    logic [PW-1:0]   s1_p;
    logic [ID_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_m     <= '0;
            s1_p     <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_zero  <= (in_data == '0);
            s1_m     <= norm_m;
            s1_p     <= lead_idx;
            s1_tag   <= in_tag;
        end
    end

    // ---------------- S2: (1+x)/2 root and odd-exponent x1.40625 ----------
    logic [M-1:0] root_half;
    logic [M:0]   root_ext;
    logic [M:0]   root_comp;

    assign root_half = (s1_m >> 1) + (M'(1) << (M-2));
    assign root_ext  = {1'b0, root_half};
    assign root_comp = root_ext + (root_ext >> 2) + (root_ext >> 3) + (root_ext >> 5);

    logic            s2_valid;
    logic            s2_zero;
    logic [M:0]      s2_s;
    logic [PW-1:0]   s2_q;
    logic [ID_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_s     <= '0;
            s2_q     <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_zero  <= s1_zero;
            s2_s     <= s1_p[0] ? root_comp : root_ext;
            s2_q     <= s1_p >> 1;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- S3: exponent shift, saturate, output register -------
    logic [RW-1:0] shifted;
    logic [RW-1:0] scaled;
    logic          sat_hit;

    assign shifted = RW'(s2_s) << s2_q;
    assign scaled  = shifted >> (M-1-FRAC);
    assign sat_hit = |scaled[RW-1:OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_tag   <= s2_tag;
            out_zero  <= s2_zero;
            out_sat   <= !s2_zero && sat_hit;
            if (s2_zero)      out_data <= '0;
            else if (sat_hit) out_data <= '1;
            else              out_data <= scaled[OUT_W-1:0];
        end
    end
endmodule
